// File: rtl/sreg_ser_if.sv
// Handshake bundle for sreg_ser: the frame input side and the word output side.
// master = frame producer / word consumer, slave = the serializer.
interface sreg_ser_if #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 3
);
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH*DEPTH-1:0] in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH-1:0]       out_data;
   logic                   out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/sreg_ser.sv
// Parallel-in / serial-out frame serializer, word 0 first, last word flagged.
// Optional one-frame skid for gapless frames: define SREG_SER_SKID_EN.
module sreg_ser #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 3
) (
   input  logic       clk,
   input  logic       sclr,
   input  logic       ce,
   sreg_ser_if.slave  bus,
   output logic       busy
);

   localparam int FW = WIDTH * DEPTH;
   localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

   if (DEPTH < 1) begin : g_depth_chk
      $error("sreg_ser: DEPTH must be >= 1");
   end

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [FW-1:0] shreg, shreg_n;
   logic          shifting;
   logic          ready_raw;
   logic          at_last;
   logic          it;
   logic          ot;

`ifdef SREG_SER_SKID_EN
   logic [FW-1:0] skid, skid_n;
   logic          skid_full, skid_full_n;
`endif

   assign shifting = (state == SHIFT);
   assign at_last  = (cnt == LAST);

`ifdef SREG_SER_SKID_EN
   assign ready_raw = ~shifting | ~skid_full;
   assign busy      = ~sclr & (shifting | skid_full);
`else
   assign ready_raw = ~shifting;
   assign busy      = ~sclr & shifting;
`endif

   // Outputs are forced quiet while reset is asserted.
   assign bus.in_ready  = ~sclr & ready_raw;
   assign bus.out_valid = ~sclr & shifting;
   assign bus.out_data  = sclr ? '0 : shreg[WIDTH-1:0];
   assign bus.out_last  = ~sclr & shifting & at_last;

   assign it = bus.in_valid & bus.in_ready & ce;
   assign ot = bus.out_valid & bus.out_ready & ce;

   // State, counter, shift and skid registers; reset wins over ce.
   always_ff @(posedge clk) begin
      if (sclr) begin
         state <= IDLE;
         cnt   <= '0;
         shreg <= '0;
`ifdef SREG_SER_SKID_EN
         skid      <= '0;
         skid_full <= 1'b0;
`endif
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         shreg <= shreg_n;
`ifdef SREG_SER_SKID_EN
         skid      <= skid_n;
         skid_full <= skid_full_n;
`endif
      end
   end

   // Next-state: load on input transfer, shift or end frame on output transfer.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      shreg_n = shreg;
`ifdef SREG_SER_SKID_EN
      skid_n      = skid;
      skid_full_n = skid_full;
`endif
      unique case (state)
         IDLE: begin
            if (it) begin
               shreg_n = bus.in_data;
               cnt_n   = '0;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
`ifdef SREG_SER_SKID_EN
            if (it) begin
               skid_n      = bus.in_data;
               skid_full_n = 1'b1;
            end
`endif
            if (ot) begin
               if (at_last) begin
                  cnt_n = '0;
`ifdef SREG_SER_SKID_EN
                  // Chain straight into the next frame when one is waiting.
                  if (skid_full) begin
                     shreg_n     = skid;
                     skid_full_n = it;
                  end else if (it) begin
                     shreg_n     = bus.in_data;
                     skid_full_n = 1'b0;
                  end else begin
                     shreg_n = '0;
                     state_n = IDLE;
                  end
`else
                  shreg_n = '0;
                  state_n = IDLE;
`endif
               end else begin
                  shreg_n = shreg >> WIDTH;
                  cnt_n   = cnt + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sreg_ser.sv
// Directed bench for sreg_ser: a 4x3 instance and an 8x1 instance,
// expected words queued at input transfer and compared at output transfer.
module tb_sreg_ser;

   logic clk = 1'b0;
   logic sclr;
   logic ce;
   logic busy_a;
   logic busy_b;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   logic [4:0] expA[$];
   logic [8:0] expB[$];
   int         otA[$];

   sreg_ser_if #(.WIDTH(4), .DEPTH(3)) ifa ();
   sreg_ser_if #(.WIDTH(8), .DEPTH(1)) ifb ();

   sreg_ser #(.WIDTH(4), .DEPTH(3)) dut_a (
      .clk  (clk),
      .sclr (sclr),
      .ce   (ce),
      .bus  (ifa),
      .busy (busy_a)
   );

   sreg_ser #(.WIDTH(8), .DEPTH(1)) dut_b (
      .clk  (clk),
      .sclr (sclr),
      .ce   (ce),
      .bus  (ifb),
      .busy (busy_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard side: every output transfer must match the queue head.
   always @(negedge clk) begin
      logic [4:0] ea;
      logic [8:0] eb;
      cyc++;
      if (!sclr && ce && ifa.out_valid && ifa.out_ready) begin
         otA.push_back(cyc);
         chk("a_unexpected", 32'(expA.size() > 0), 1);
         if (expA.size() > 0) begin
            ea = expA.pop_front();
            chk("a_word", {ifa.out_last, ifa.out_data}, ea);
         end
      end
      if (!sclr && ce && ifb.out_valid && ifb.out_ready) begin
         chk("b_unexpected", 32'(expB.size() > 0), 1);
         if (expB.size() > 0) begin
            eb = expB.pop_front();
            chk("b_word", {ifb.out_last, ifb.out_data}, eb);
         end
      end
   end

   task automatic send_a(input logic [11:0] f);
      bit ok = 1'b0;
      ifa.in_valid = 1'b1;
      ifa.in_data  = f;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ifa.in_ready && ce && !sclr) begin
            ok = 1'b1;
            break;
         end
      end
      chk("send_a_timeout", 32'(ok), 1);
      if (ok)
         for (int k = 0; k < 3; k++)
            expA.push_back({k == 2, f[k*4 +: 4]});
      @(posedge clk);
      #1;
      ifa.in_valid = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] f);
      bit ok = 1'b0;
      ifb.in_valid = 1'b1;
      ifb.in_data  = f;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ifb.in_ready && ce && !sclr) begin
            ok = 1'b1;
            break;
         end
      end
      chk("send_b_timeout", 32'(ok), 1);
      if (ok) expB.push_back({1'b1, f});
      @(posedge clk);
      #1;
      ifb.in_valid = 1'b0;
   endtask

   task automatic drain_a();
      for (int i = 0; i < 100; i++) begin
         if (expA.size() == 0 && !busy_a) break;
         tick();
      end
      chk("drain_a", 32'(expA.size()), 0);
      chk("drain_a_busy", 32'(busy_a), 0);
   endtask

   task automatic drain_b();
      for (int i = 0; i < 100; i++) begin
         if (expB.size() == 0 && !busy_b) break;
         tick();
      end
      chk("drain_b", 32'(expB.size()), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       rdy_pat [5];
      logic [4:0] exp_pat [5];
      int         span;
      logic       rdy_busy;
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_pat = '{5'h0A, 5'h0B, 5'h0B, 5'h0B, 5'h1C};
`ifdef SREG_SER_SKID_EN
      span     = 5;
      rdy_busy = 1'b1;
`else
      span     = 6;
      rdy_busy = 1'b0;
`endif
      sclr          = 1'b1;
      ce            = 1'b1;
      ifa.in_valid  = 1'b0;
      ifa.in_data   = '0;
      ifa.out_ready = 1'b0;
      ifb.in_valid  = 1'b0;
      ifb.in_data   = '0;
      ifb.out_ready = 1'b0;
      tick();
      tick();

      // reset state
      chk("rst_out_valid", 32'(ifa.out_valid), 0);
      chk("rst_busy", 32'(busy_a), 0);
      chk("rst_in_ready", 32'(ifa.in_ready), 0);
      chk("rst_out_data", 32'(ifa.out_data), 0);
      chk("rst_out_last", 32'(ifa.out_last), 0);
      sclr = 1'b0;
      #1;
      chk("idle_in_ready", 32'(ifa.in_ready), 1);
      chk("idle_out_valid", 32'(ifa.out_valid), 0);

      // 1: basic, latency 1, consecutive words
      ifa.out_ready = 1'b1;
      otA.delete();
      send_a(12'hCBA);
      chk("lat_valid", 32'(ifa.out_valid), 1);
      chk("lat_word", {ifa.out_last, ifa.out_data}, 5'h0A);
      chk("shift_in_ready", 32'(ifa.in_ready), 32'(rdy_busy));
      chk("shift_busy", 32'(busy_a), 1);
      drain_a();
      chk("basic_count", 32'(otA.size()), 3);
      if (otA.size() == 3)
         chk("basic_span", 32'(otA[2] - otA[0]), 2);

      // 2: backpressure
      ifa.out_ready = 1'b0;
      otA.delete();
      send_a(12'hCBA);
      for (int s = 0; s < 5; s++) begin
         ifa.out_ready = rdy_pat[s];
         #1;
         chk("bp_word", {ifa.out_last, ifa.out_data}, exp_pat[s]);
         tick();
      end
      drain_a();
      chk("bp_count", 32'(otA.size()), 3);

      // 3: ce gating mid-frame
      ifa.out_ready = 1'b1;
      send_a(12'hCBA);
      tick();
      ce = 1'b0;
      for (int s = 0; s < 4; s++) begin
         #1;
         chk("ce_word", {ifa.out_valid, ifa.out_data}, 5'h1B);
         tick();
      end
      chk("ce_resume", {ifa.out_last, ifa.out_data}, 5'h0B);
      ce = 1'b1;
      drain_a();

      // 4: reset mid-frame
      send_a(12'hCBA);
      tick();
      sclr = 1'b1;
      tick();
      expA.delete();
      sclr = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(ifa.out_valid), 0);
      chk("mid_rst_busy", 32'(busy_a), 0);
      chk("mid_rst_ready", 32'(ifa.in_ready), 1);
      send_a(12'h321);
      chk("post_rst_word", {ifa.out_last, ifa.out_data}, 5'h01);
      drain_a();

      // 5: back-to-back frames
      otA.delete();
      send_a(12'hCBA);
      send_a(12'h654);
      drain_a();
      chk("b2b_count", 32'(otA.size()), 6);
      if (otA.size() == 6)
         chk("b2b_span", 32'(otA[5] - otA[0]), 32'(span));

      // 6: DEPTH=1
      ifb.out_ready = 1'b1;
      send_b(8'h5A);
      chk("d1_word", {ifb.out_valid, ifb.out_last, ifb.out_data}, 10'h35A);
      send_b(8'hA5);
      drain_b();
      chk("d1_busy", 32'(busy_b), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
